// File: rtl/ct_mat_exu_mma_seq.sv
// MMA sequencer: latches M/N/K at accept, walks m(outer)/n/k(inner) emitting MAC micro-ops, then completes on cbus.
// Optional MAT_SEQ_STALL_CNT_EN builds a saturating stall-cycle counter; otherwise mat_seq_stall_cnt is 0.
module ct_mat_exu_mma_seq #(
   parameter int unsigned K_STEP = 4
) (
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        rtu_yy_xx_flush,
   input  logic        idu_mat_mma_vld,
   input  logic [6:0]  idu_mat_mma_iid,
   output logic        mat_seq_idu_rdy,
   input  logic [7:0]  x_sizeM,
   input  logic [7:0]  x_sizeN,
   input  logic [15:0] x_sizeK,
   output logic        mat_seq_uop_vld,
   input  logic        mac_seq_uop_rdy,
   output logic [7:0]  mat_seq_uop_m_idx,
   output logic [7:0]  mat_seq_uop_n_idx,
   output logic [15:0] mat_seq_uop_k_idx,
   output logic        mat_seq_uop_first_k,
   output logic        mat_seq_uop_last_k,
   output logic        mat_seq_cbus_cmplt,
   output logic [6:0]  mat_seq_cbus_iid,
   output logic [31:0] mat_seq_stall_cnt
);

   localparam int unsigned KS_LOG2 = $clog2(K_STEP);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CMPLT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [6:0]  r_iid;
   logic [7:0]  r_size_m;
   logic [7:0]  r_size_n;
   logic [15:0] r_kstep_num;
   logic [7:0]  r_m;
   logic [7:0]  r_n;
   logic [15:0] r_k;

   logic [16:0] w_ksum;
   logic [15:0] w_kstep_num;
   logic [15:0] w_k_last;
   logic        w_accept;
   logic        w_size_zero;
   logic        w_fire;
   logic        w_last_k;
   logic        w_last_n;
   logic        w_last_m;

   // ceil(sizeK / K_STEP) computed one bit wider so sizeK near 0xFFFF cannot overflow
   assign w_ksum      = {1'b0, x_sizeK} + 17'(K_STEP - 1);
   assign w_kstep_num = 16'(w_ksum >> KS_LOG2);
   assign w_size_zero = (x_sizeM == 8'd0) | (x_sizeN == 8'd0) | (w_kstep_num == 16'd0);
   assign w_accept    = idu_mat_mma_vld & (r_state == S_IDLE) & ~rtu_yy_xx_flush;
   assign w_fire      = (r_state == S_RUN) & mac_seq_uop_rdy;

   assign w_k_last = (r_kstep_num - 16'd1) << KS_LOG2;
   assign w_last_k = (r_k == w_k_last);
   assign w_last_n = (r_n == r_size_n - 8'd1);
   assign w_last_m = (r_m == r_size_m - 8'd1);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_size_zero ? S_CMPLT : S_RUN;
         S_RUN:   if (w_fire && w_last_k && w_last_n && w_last_m) w_state_nxt = S_CMPLT;
         S_CMPLT: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (rtu_yy_xx_flush) w_state_nxt = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_iid       <= '0;
         r_size_m    <= '0;
         r_size_n    <= '0;
         r_kstep_num <= '0;
         r_m         <= '0;
         r_n         <= '0;
         r_k         <= '0;
      end else if (w_accept) begin
         r_iid       <= idu_mat_mma_iid;
         r_size_m    <= x_sizeM;
         r_size_n    <= x_sizeN;
         r_kstep_num <= w_kstep_num;
         r_m         <= '0;
         r_n         <= '0;
         r_k         <= '0;
      end else if (w_fire && !rtu_yy_xx_flush) begin
         // m is held on the final fire so the counters never run past the latched sizes
         if (w_last_k) begin
            r_k <= '0;
            if (w_last_n) begin
               r_n <= '0;
               if (!w_last_m) r_m <= r_m + 8'd1;
            end else begin
               r_n <= r_n + 8'd1;
            end
         end else begin
            r_k <= r_k + 16'(K_STEP);
         end
      end
   end

`ifdef MAT_SEQ_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_RUN) && !mac_seq_uop_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign mat_seq_stall_cnt = r_stall_cnt;
`else
   assign mat_seq_stall_cnt = '0;
`endif

   assign mat_seq_idu_rdy     = (r_state == S_IDLE);
   assign mat_seq_uop_vld     = (r_state == S_RUN);
   assign mat_seq_uop_m_idx   = r_m;
   assign mat_seq_uop_n_idx   = r_n;
   assign mat_seq_uop_k_idx   = r_k;
   assign mat_seq_uop_first_k = mat_seq_uop_vld & (r_k == 16'd0);
   assign mat_seq_uop_last_k  = mat_seq_uop_vld & w_last_k;
   assign mat_seq_cbus_cmplt  = (r_state == S_CMPLT);
   assign mat_seq_cbus_iid    = mat_seq_cbus_cmplt ? r_iid : 7'd0;

endmodule
